// File: rtl/uart_tx_frame.sv
// uart_tx_frame: serializes one byte per accepted request as
// start bit, 8 data bits (LSB first), optional parity bit and one stop bit.
// Ports: clk, reset (sync, active-high), start/data_in (request + byte),
//        tx (registered serial line, idles high), busy (frame in progress),
//        done (one-cycle pulse after the stop bit).
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int PARITY       = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
    // Unsupported parity codes fall back to no parity.
    localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
    localparam bit PAR_ODD = (PARITY == 2);

    state_t      r_state;
    state_t      w_state_n;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_n;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_n;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_n;
    logic        r_par;
    logic        w_par_n;
    logic        r_tx;
    logic        w_tx_n;
    logic        w_last;

    assign w_last = (r_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_idx   <= w_idx_n;
            r_shift <= w_shift_n;
            r_par   <= w_par_n;
            r_tx    <= w_tx_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_idx_n   = r_idx;
        w_shift_n = r_shift;
        w_par_n   = r_par;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_n = S_START;
                    w_cnt_n   = '0;
                    w_idx_n   = '0;
                    w_shift_n = data_in;
                    w_par_n   = PAR_ODD ? ~^data_in : ^data_in;
                end
            end
            S_START: begin
                if (w_last) begin
                    w_cnt_n   = '0;
                    w_state_n = S_DATA;
                end else begin
                    w_cnt_n = r_cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (w_last) begin
                    w_cnt_n   = '0;
                    w_shift_n = {1'b0, r_shift[7:1]};
                    if (r_idx == 3'd7) begin
                        w_idx_n   = '0;
                        w_state_n = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        w_idx_n = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_n = r_cnt + 16'd1;
                end
            end
            S_PARITY: begin
                if (w_last) begin
                    w_cnt_n   = '0;
                    w_state_n = S_STOP;
                end else begin
                    w_cnt_n = r_cnt + 16'd1;
                end
            end
            S_STOP: begin
                if (w_last) begin
                    w_cnt_n   = '0;
                    w_state_n = S_DONE;
                end else begin
                    w_cnt_n = r_cnt + 16'd1;
                end
            end
            S_DONE: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // tx is registered from the next state so the line level is
    // glitch-free and aligned with the state it belongs to.
    always_comb begin
        w_tx_n = 1'b1;
        unique case (w_state_n)
            S_START:  w_tx_n = 1'b0;
            S_DATA:   w_tx_n = w_shift_n[0];
            S_PARITY: w_tx_n = w_par_n;
            default:  w_tx_n = 1'b1;
        endcase
    end

    assign tx   = r_tx;
    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed bench for uart_tx_frame with CLKS_PER_BIT=4,
// three instances sharing inputs (no parity, even parity, odd parity).
module tb_uart_tx_frame;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] data_in;
    logic       tx0, busy0, done0;
    logic       tx1, busy1, done1;
    logic       tx2, busy2, done2;

    int n_tests = 0;
    int n_fail  = 0;

    logic a_tx0 [0:127];
    logic a_busy0 [0:127];
    logic a_done0 [0:127];
    logic a_tx1 [0:127];
    logic a_done1 [0:127];
    logic a_tx2 [0:127];
    logic a_done2 [0:127];

    uart_tx_frame #(.CLKS_PER_BIT(4), .PARITY(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in),
        .tx(tx0), .busy(busy0), .done(done0)
    );
    uart_tx_frame #(.CLKS_PER_BIT(4), .PARITY(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in),
        .tx(tx1), .busy(busy1), .done(done1)
    );
    uart_tx_frame #(.CLKS_PER_BIT(4), .PARITY(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in),
        .tx(tx2), .busy(busy2), .done(done2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Expected line level in cycle k (1-based, cycle 1 follows the
    // accepting edge) for a 4-clock bit period.
    function automatic logic exp_tx(input logic [7:0] d, input int pm,
                                    input int k);
        int p;
        p = (k - 1) / 4;
        if (p == 0) return 1'b0;
        if (p <= 8) return d[p-1];
        if (pm == 1 && p == 9) return ^d;
        if (pm == 2 && p == 9) return ~^d;
        return 1'b1;
    endfunction

    // Advance one cycle and record outputs 1 time unit after the edge.
    task automatic step(input int k);
        @(posedge clk);
        #1;
        if (k >= 0 && k < 128) begin
            a_tx0[k]   = tx0;
            a_busy0[k] = busy0;
            a_done0[k] = done0;
            a_tx1[k]   = tx1;
            a_done1[k] = done1;
            a_tx2[k]   = tx2;
            a_done2[k] = done2;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(-1);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        data_in = 8'h00;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) reset = 1'b0;
            step(-1);
            n_tests++;
            if ({tx0, busy0, done0} !== 3'b100) begin
                n_fail++;
                $display("FAIL reset cyc%0d: tx/busy/done=%b%b%b want 100",
                         i, tx0, busy0, done0);
            end
        end
    endtask

    task automatic test_single;
        data_in = 8'hA5;
        start = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            step(k);
            if (k == 1) start = 1'b0;
        end
        for (int k = 1; k <= 44; k++) begin
            n_tests++;
            if (a_tx0[k] !== exp_tx(8'hA5, 0, k)) begin
                n_fail++;
                $display("FAIL single tx cyc%0d: got %b want %b",
                         k, a_tx0[k], exp_tx(8'hA5, 0, k));
            end
            n_tests++;
            if (a_busy0[k] !== (k <= 41)) begin
                n_fail++;
                $display("FAIL single busy cyc%0d: got %b want %b",
                         k, a_busy0[k], (k <= 41));
            end
            n_tests++;
            if (a_done0[k] !== (k == 41)) begin
                n_fail++;
                $display("FAIL single done cyc%0d: got %b want %b",
                         k, a_done0[k], (k == 41));
            end
        end
        idle(2);
    endtask

    task automatic test_parity;
        data_in = 8'h07;
        start = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            step(k);
            if (k == 1) start = 1'b0;
        end
        for (int k = 1; k <= 48; k++) begin
            n_tests++;
            if (a_tx1[k] !== exp_tx(8'h07, 1, k)) begin
                n_fail++;
                $display("FAIL even tx cyc%0d: got %b want %b",
                         k, a_tx1[k], exp_tx(8'h07, 1, k));
            end
            n_tests++;
            if (a_tx2[k] !== exp_tx(8'h07, 2, k)) begin
                n_fail++;
                $display("FAIL odd tx cyc%0d: got %b want %b",
                         k, a_tx2[k], exp_tx(8'h07, 2, k));
            end
            n_tests++;
            if (a_done1[k] !== (k == 45) || a_done2[k] !== (k == 45)) begin
                n_fail++;
                $display("FAIL parity done cyc%0d: got %b%b want %b",
                         k, a_done1[k], a_done2[k], (k == 45));
            end
        end
        // Hand values: parity period is cycles 37..40.
        n_tests++;
        if (a_tx1[38] !== 1'b1 || a_tx2[38] !== 1'b0) begin
            n_fail++;
            $display("FAIL parity bit: even=%b odd=%b want 1/0",
                     a_tx1[38], a_tx2[38]);
        end
        idle(2);
    endtask

    task automatic test_ignored_start;
        int nd;
        nd = 0;
        data_in = 8'hFF;
        start = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            step(k);
            if (k == 1) start = 1'b0;
            if (k == 12) begin
                data_in = 8'h3C;
                start = 1'b1;
            end
            if (k == 13) start = 1'b0;
            if (k == 41) start = 1'b1;
            if (k == 42) start = 1'b0;
        end
        for (int k = 1; k <= 41; k++) begin
            n_tests++;
            if (a_tx0[k] !== exp_tx(8'hFF, 0, k)) begin
                n_fail++;
                $display("FAIL ignored tx cyc%0d: got %b want %b",
                         k, a_tx0[k], exp_tx(8'hFF, 0, k));
            end
        end
        for (int k = 1; k <= 41; k++) if (a_done0[k] === 1'b1) nd++;
        n_tests++;
        if (nd != 1) begin
            n_fail++;
            $display("FAIL ignored done count: got %0d want 1", nd);
        end
        // start raised during the DONE cycle must not launch a frame.
        n_tests++;
        if (a_busy0[43] !== 1'b0 || a_tx0[43] !== 1'b1) begin
            n_fail++;
            $display("FAIL ignored done-cycle start: busy=%b tx=%b want 0/1",
                     a_busy0[43], a_tx0[43]);
        end
        idle(2);
    endtask

    task automatic test_back_to_back;
        int nd;
        int hi;
        logic e;
        nd = 0;
        hi = 0;
        data_in = 8'h01;
        start = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            step(k);
            if (k == 1) data_in = 8'h80;
            if (k == 43) start = 1'b0;
        end
        for (int k = 1; k <= 86; k++) begin
            if (k <= 42) e = exp_tx(8'h01, 0, k);
            else e = exp_tx(8'h80, 0, k - 42);
            n_tests++;
            if (a_tx0[k] !== e) begin
                n_fail++;
                $display("FAIL b2b tx cyc%0d: got %b want %b", k, a_tx0[k], e);
            end
            if (a_done0[k] === 1'b1) nd++;
        end
        for (int k = 37; k <= 43 && a_tx0[k] === 1'b1; k++) hi++;
        n_tests++;
        if (hi != 6) begin
            n_fail++;
            $display("FAIL b2b gap: got %0d high cycles want 6", hi);
        end
        n_tests++;
        if (nd != 2 || a_done0[41] !== 1'b1 || a_done0[83] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b done: count %0d d41=%b d83=%b want 2/1/1",
                     nd, a_done0[41], a_done0[83]);
        end
        idle(2);
    endtask

    task automatic test_mid_reset;
        int nd;
        nd = 0;
        data_in = 8'hF0;
        start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step(k);
            if (k == 1) start = 1'b0;
            if (k == 18) reset = 1'b1;
            if (k == 19) reset = 1'b0;
        end
        n_tests++;
        if (a_tx0[18] !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset pre tx: got %b want 0", a_tx0[18]);
        end
        n_tests++;
        if (a_tx0[19] !== 1'b1 || a_busy0[19] !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset post: tx=%b busy=%b want 1/0",
                     a_tx0[19], a_busy0[19]);
        end
        for (int k = 19; k <= 30; k++) if (a_done0[k] !== 1'b0) nd++;
        n_tests++;
        if (nd != 0) begin
            n_fail++;
            $display("FAIL midreset done: got %0d cycles high want 0", nd);
        end
        data_in = 8'h55;
        start = 1'b1;
        for (int k = 1; k <= 44; k++) begin
            step(k);
            if (k == 1) start = 1'b0;
        end
        for (int k = 1; k <= 44; k++) begin
            n_tests++;
            if (a_tx0[k] !== exp_tx(8'h55, 0, k)) begin
                n_fail++;
                $display("FAIL midreset frame tx cyc%0d: got %b want %b",
                         k, a_tx0[k], exp_tx(8'h55, 0, k));
            end
        end
        n_tests++;
        if (a_done0[41] !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset frame done: got %b want 1", a_done0[41]);
        end
        idle(4);
    endtask

    task automatic test_start_with_reset;
        reset = 1'b1;
        start = 1'b1;
        data_in = 8'h00;
        step(1);
        reset = 1'b0;
        start = 1'b0;
        step(2);
        n_tests++;
        if (a_busy0[1] !== 1'b0 || a_tx0[2] !== 1'b1 || a_busy0[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL start+reset: busy=%b/%b tx=%b want 0/0/1",
                     a_busy0[1], a_busy0[2], a_tx0[2]);
        end
        idle(2);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        data_in = 8'h00;
        test_reset();
        test_single();
        test_parity();
        test_ignored_start();
        test_back_to_back();
        test_mid_reset();
        test_start_with_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
